// File: rtl/icache_axi_pkg.sv
// Shared encodings for the I-cache AXI line-refill master: burst types, response codes,
// fixed AR attributes, FSM states and a constant-friendly log2 helper.
package icache_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Instruction fetch, secure, unprivileged; modifiable non-bufferable.
  localparam logic [2:0] ARPROT_IFETCH = 3'b100;
  localparam logic [3:0] ARCACHE_DEF   = 4'b0010;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StDone,
    StDrain
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// Line assembly buffer: beats are written at their word index, and the completed line is
// copied to a separate output register so the last delivered line stays visible during refills.
module icache_line_buf
  import icache_axi_pkg::*;
#(
  parameter int unsigned WidthData = 32,
  parameter int unsigned NWord     = 8,
  localparam int unsigned IdxW     = clog2(NWord)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       we_i,
  input  logic [IdxW-1:0]            idx_i,
  input  logic [WidthData-1:0]       wdata_i,
  input  logic                       commit_i,
  output logic [NWord*WidthData-1:0] line_o
);

  logic [NWord-1:0][WidthData-1:0] mem_q;
  logic [NWord-1:0][WidthData-1:0] line_q;
  logic [NWord-1:0][WidthData-1:0] merged;

  // Commit coincides with the final beat, so fold that beat in on the way out.
  always_comb begin
    merged        = mem_q;
    merged[idx_i] = wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q  <= '0;
      line_q <= '0;
    end else begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      if (commit_i) line_q <= merged;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/icache_axi_refill.sv
// AXI4 read-burst master refilling one I-cache line per miss, with optional wrap
// (critical-word-first) bursts, RRESP/RLAST checking and cancel-with-drain.
module icache_axi_refill
  import icache_axi_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 32,
  parameter int unsigned N_WORD     = 8,
  parameter int unsigned WIDTH_ADD  = 32,
  parameter int unsigned CRIT_FIRST = 0
) (
  input  logic                         AXI_CLK,
  input  logic                         AXI_RESETn,
  input  logic                         RD_REQ_MEM,
  input  logic [WIDTH_ADD-1:0]         RD_ADD_MEM,
  input  logic                         RD_CANCEL_MEM,
  output logic [WIDTH_DATA*N_WORD-1:0] Data_RD_MEM,
  output logic                         RD_Valid_MEM,
  output logic                         RD_Err_MEM,
  output logic                         Busy,
  output logic                         AXI_ARVALID,
  input  logic                         AXI_ARREADY,
  output logic [WIDTH_ADD-1:0]         AXI_ARADDR,
  output logic [7:0]                   AXI_ARLEN,
  output logic [2:0]                   AXI_ARSIZE,
  output logic [1:0]                   AXI_ARBURST,
  output logic [2:0]                   AXI_ARPROT,
  output logic [3:0]                   AXI_ARCACHE,
  input  logic                         AXI_RVALID,
  output logic                         AXI_RREADY,
  input  logic [WIDTH_DATA-1:0]        AXI_RDATA,
  input  logic [1:0]                   AXI_RRESP,
  input  logic                         AXI_RLAST
);

  localparam int unsigned OffW     = clog2(WIDTH_DATA / 8);
  localparam int unsigned IdxW     = clog2(N_WORD);
  localparam int unsigned LineOffW = OffW + IdxW;
  localparam logic [WIDTH_ADD-1:0] AddrMask = (CRIT_FIRST != 0) ?
      ({WIDTH_ADD{1'b1}} << OffW) : ({WIDTH_ADD{1'b1}} << LineOffW);
  localparam logic [IdxW-1:0] LastCnt = IdxW'(N_WORD - 1);

  state_e               state_q;
  logic [IdxW-1:0]      idx_q, cnt_q;
  logic                 err_q, cancel_q;
  logic                 arvalid_q, rready_q, valid_q, err_out_q, busy_q;
  logic [WIDTH_ADD-1:0] araddr_q;
  logic [7:0]           arlen_q;
  logic [2:0]           arsize_q, arprot_q;
  logic [1:0]           arburst_q;
  logic [3:0]           arcache_q;

  logic beat, last_beat, beat_err, buf_we, buf_commit;

  assign beat      = AXI_RVALID && rready_q;
  assign last_beat = (cnt_q == LastCnt);
  assign beat_err  = (AXI_RRESP == RESP_SLVERR) || (AXI_RRESP == RESP_DECERR) ||
                     (AXI_RLAST != last_beat);

  assign buf_we     = (state_q == StData) && beat;
  assign buf_commit = buf_we && last_beat && !RD_CANCEL_MEM;

  always_ff @(posedge AXI_CLK or negedge AXI_RESETn) begin
    if (!AXI_RESETn) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      cancel_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_out_q <= 1'b0;
      busy_q    <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      arprot_q  <= '0;
      arcache_q <= '0;
    end else begin
      valid_q   <= 1'b0;
      err_out_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (RD_REQ_MEM) begin
            state_q   <= StAddr;
            busy_q    <= 1'b1;
            arvalid_q <= 1'b1;
            araddr_q  <= RD_ADD_MEM & AddrMask;
            arlen_q   <= 8'(N_WORD - 1);
            arsize_q  <= 3'(OffW);
            arburst_q <= (CRIT_FIRST != 0) ? BURST_WRAP : BURST_INCR;
            arprot_q  <= ARPROT_IFETCH;
            arcache_q <= ARCACHE_DEF;
            idx_q     <= (CRIT_FIRST != 0) ? RD_ADD_MEM[OffW +: IdxW] : '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            cancel_q  <= 1'b0;
          end
        end
        StAddr: begin
          // The AR request cannot be withdrawn, so a cancel here is remembered for later.
          if (RD_CANCEL_MEM) cancel_q <= 1'b1;
          if (AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= (cancel_q || RD_CANCEL_MEM) ? StDrain : StData;
          end
        end
        StData: begin
          if (beat) begin
            idx_q <= idx_q + IdxW'(1);
            cnt_q <= cnt_q + IdxW'(1);
            if (beat_err) err_q <= 1'b1;
          end
          if (beat && last_beat) begin
            rready_q <= 1'b0;
            if (RD_CANCEL_MEM) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= StDone;
              valid_q   <= 1'b1;
              err_out_q <= err_q || beat_err;
            end
          end else if (RD_CANCEL_MEM) begin
            state_q <= StDrain;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        StDrain: begin
          if (beat) begin
            cnt_q <= cnt_q + IdxW'(1);
            if (last_beat) begin
              rready_q <= 1'b0;
              state_q  <= StIdle;
              busy_q   <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  icache_line_buf #(
    .WidthData (WIDTH_DATA),
    .NWord     (N_WORD)
  ) u_line_buf (
    .clk_i    (AXI_CLK),
    .rst_ni   (AXI_RESETn),
    .we_i     (buf_we),
    .idx_i    (idx_q),
    .wdata_i  (AXI_RDATA),
    .commit_i (buf_commit),
    .line_o   (Data_RD_MEM)
  );

  assign RD_Valid_MEM = valid_q;
  assign RD_Err_MEM   = err_out_q;
  assign Busy         = busy_q;
  assign AXI_ARVALID  = arvalid_q;
  assign AXI_ARADDR   = araddr_q;
  assign AXI_ARLEN    = arlen_q;
  assign AXI_ARSIZE   = arsize_q;
  assign AXI_ARBURST  = arburst_q;
  assign AXI_ARPROT   = arprot_q;
  assign AXI_ARCACHE  = arcache_q;
  assign AXI_RREADY   = rready_q;

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

AXI4 read-burst master that refills one instruction-cache line per miss. It sits between the I-cache miss logic and the AXI interconnect. It issues a single AR burst of N_WORD beats, collects the R beats into a line buffer and returns the full line with a one-cycle valid pulse and an error flag. Over the single-beat I-cache AXI adapter it adds real valid/ready handshakes, parametrised line length, optional critical-word-first WRAP bursts, RLAST/RRESP checking and cancel-with-drain.

## Interface
Parameters:
- WIDTH_DATA, 32, R beat width in bits (32 or 64)
- N_WORD, 8, beats per line (2, 4, 8 or 16)
- WIDTH_ADD, 32, address width
- CRIT_FIRST, 0, 0 = line-aligned INCR burst; 1 = WRAP burst starting at the requested word

Ports:
- AXI_CLK  in  1  single clock; all logic on the rising edge
- AXI_RESETn  in  1  asynchronous, active-low reset
- RD_REQ_MEM  in  1  miss request; held high until RD_Valid_MEM or cancel
- RD_ADD_MEM  in  WIDTH_ADD  miss address (byte address)
- RD_CANCEL_MEM  in  1  abandon the current refill (branch flush)
- Data_RD_MEM  out  WIDTH_DATA*N_WORD  assembled line; word i at bits [i*WIDTH_DATA +: WIDTH_DATA]
- RD_Valid_MEM  out  1  one-cycle pulse: line complete
- RD_Err_MEM  out  1  qualifies RD_Valid_MEM: bad RRESP or RLAST mismatch
- Busy  out  1  high in every state except IDLE
- AXI_ARVALID / AXI_ARREADY  out / in  1  AR handshake
- AXI_ARADDR  out  WIDTH_ADD
- AXI_ARLEN  out  8
- AXI_ARSIZE  out  3
- AXI_ARBURST  out  2
- AXI_ARPROT  out  3
- AXI_ARCACHE  out  4
- AXI_RVALID / AXI_RREADY  in / out  1  R handshake
- AXI_RDATA  in  WIDTH_DATA
- AXI_RRESP  in  2
- AXI_RLAST  in  1

## Operation
States and transitions:
- IDLE: RD_REQ_MEM=1 latches the address and goes to ADDR.
- ADDR: ARVALID=1. On ARREADY, go to DATA.
- DATA: RREADY=1. On the last beat, go to DONE.
- DONE: RD_Valid_MEM=1 for one cycle, then IDLE.
- DRAIN: RREADY=1, beats are discarded. On the last beat, go to IDLE.

AR fields, all registered and stable while ARVALID=1:
- ARLEN=N_WORD-1; ARSIZE=log2(WIDTH_DATA/8); ARPROT=3'b100 (instruction, secure, unprivileged); ARCACHE=4'b0010.
- CRIT_FIRST=0: ARADDR is the address with its low log2(N_WORD*WIDTH_DATA/8) bits cleared; ARBURST=INCR (2'b01).
- CRIT_FIRST=1: ARADDR is the address with its low log2(WIDTH_DATA/8) bits cleared; ARBURST=WRAP (2'b10).

Beat placement:
- Beat index starts at 0 (INCR) or at the requested word index (WRAP).
- Increments modulo N_WORD per accepted beat.
- Beat count runs 0..N_WORD-1 independently; the last beat is count==N_WORD-1.

Errors (sticky per refill, cleared on IDLE→ADDR):
- Any beat with RRESP[1]=1 (SLVERR/DECERR) sets the error.
- RLAST=1 on a beat other than the last, or RLAST=0 on the last beat, sets the error.
- Completion is always by beat count. The line is still delivered, with RD_Err_MEM=1.

Cancel:
- In ADDR: ARVALID stays high until ARREADY (no AR withdrawal), then go to DRAIN.
- In DATA: go to DRAIN on the next edge. Beats already accepted are discarded.
- In IDLE or DONE: ignored. A DONE pulse already issued stands.
- Cancel produces no RD_Valid_MEM. A new RD_REQ_MEM is accepted only after DRAIN returns to IDLE.
- RD_REQ_MEM outside IDLE is ignored.

Data_RD_MEM holds the last completed line until the next DONE. It is undefined-but-stable during a refill.

## Timing
- Reset values: all outputs 0, including Data_RD_MEM, ARADDR and ARLEN; state IDLE; counters 0. Asynchronous assertion; reset mid-burst abandons the burst with no drain.
- Requests are registered: request sampled at edge 0, ARVALID high from cycle 1.
- Minimum latency, with ARREADY and RVALID always high:
  - AR handshake in cycle 1.
  - Beats in cycles 2..N_WORD+1.
  - RD_Valid_MEM in cycle N_WORD+2; IDLE in N_WORD+3.
- RVALID gaps stall the beat counter. RREADY never drops in DATA or DRAIN.
- Requester contract: drop RD_REQ_MEM at the edge after RD_Valid_MEM. A request seen in the IDLE cycle after DONE is a new miss.

## Structure
- Package icache_axi_pkg holds:
  - Burst encodings (INCR, WRAP).
  - RRESP codes.
  - ARPROT_IFETCH=3'b100 and ARCACHE_DEF=4'b0010.
  - State encoding (IDLE, ADDR, DATA, DONE, DRAIN).
  - A clog2 helper.
- One sub-module, icache_line_buf: an N_WORD×WIDTH_DATA register file with a write-enable at the beat index and a flat line output.

## Test plan
- INCR, N_WORD=8: request 0x1000_0014 with ARREADY/RVALID tied high → ARADDR=0x1000_0000, ARLEN=7, ARBURST=01, ARSIZE=2. RD_Valid_MEM at cycle 10 with the line equal to beats 0..7. RD_Err_MEM=0.
- CRIT_FIRST=1: request 0x2000_0018 → ARADDR=0x2000_0018, ARBURST=10. Beats D0..D7 land at words 6,7,0,1,…,5.
- Backpressure: ARREADY delayed 3 cycles and random RVALID gaps → ARADDR stable while ARVALID=1. Exactly one RD_Valid_MEM with the correct line.
- Errors: RRESP=2'b10 on beat 3 → RD_Err_MEM=1 with RD_Valid_MEM. Separately, RLAST on beat 5 → RD_Err_MEM=1, still 8 beats accepted.
- Cancel at beat 2 → no RD_Valid_MEM, remaining beats accepted, Busy falls after beat 7. A following request refills correctly.
- Reset asserted mid-DATA → all outputs 0 immediately, state IDLE.
